// File: rtl/platform_motion_controller.sv
// Single-slot platform mover: takes one descriptor per 4-phase handshake,
// steps it on a frame tick, saturates it to the playfield and retires it
// on timer, player contact or screen edge.
module platform_motion_controller #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int TICK_CYCLES = 1666666
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync_platform_position,
    input  logic [2:0] movement_direction,
    input  logic [4:0] speed,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [9:0] w,
    input  logic [9:0] h,
    input  logic [7:0] destroy_time,
    input  logic [1:0] destroy_trigger,
    input  logic       player_contact,
    output logic       update_platform_position,
    output logic       platform_active,
    output logic [9:0] plat_x,
    output logic [9:0] plat_y,
    output logic [9:0] plat_w,
    output logic [9:0] plat_h,
    output logic       platform_destroyed
);

    localparam int              TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [10:0]     SW        = 11'(SCREEN_W);
    localparam logic [10:0]     SH        = 11'(SCREEN_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACK,
        S_ACTIVE,
        S_DRAIN      // platform already retired, still waiting for sync to rise
    } state_t;

    state_t             state, next_state;
    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [2:0]         dir_q;
    logic [4:0]         spd_q;
    logic [1:0]         trig_q;
    logic [7:0]         life;
    logic               live;
    logic               up, down, left, right;
    logic signed [11:0] step_x, step_y, sx, sy;
    logic [10:0]        sat_x, sat_y;
    logic               moving, edge_hit;
    logic               contact_kill, timer_kill, edge_kill;
    logic               destroy, move_en;

    // Clamp a signed coordinate into [0, hi]; bit 10 flags that clamping occurred.
    function automatic logic [10:0] sat_axis(input logic signed [11:0] v, input logic [9:0] hi);
        logic [10:0] r;
        if (v < 12'sd0)
            r = {1'b1, 10'd0};
        else if (v > $signed({2'b00, hi}))
            r = {1'b1, hi};
        else
            r = {1'b0, v[9:0]};
        return r;
    endfunction

    // Largest legal top-left coordinate; an oversized platform is pinned at 0.
    function automatic logic [9:0] axis_bound(input logic [10:0] screen, input logic [9:0] size);
        if ({1'b0, size} >= screen)
            return 10'd0;
        else
            return 10'(screen - {1'b0, size});
    endfunction

    // Signed per-tick displacement along one axis.
    function automatic logic signed [11:0] axis_step(input logic neg, input logic pos, input logic [4:0] s);
        logic signed [11:0] m;
        m = $signed({7'd0, s});
        if (neg)
            return -m;
        else if (pos)
            return m;
        else
            return 12'sd0;
    endfunction

    assign tick = (tick_cnt == TICK_LAST);
    // Movement/destroy logic is live in ACK, and in ACTIVE unless a new descriptor is arriving.
    assign live = (state == S_ACK) || ((state == S_ACTIVE) && sync_platform_position);

    // Free-running frame tick counter, independent of FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // Next position, saturation and retirement conditions for the current tick.
    always_comb begin
        up           = dir_q inside {3'd1, 3'd5, 3'd6};
        down         = dir_q inside {3'd2, 3'd7};
        left         = dir_q inside {3'd3, 3'd5};
        right        = dir_q inside {3'd4, 3'd6, 3'd7};
        step_x       = axis_step(left, right, spd_q);
        step_y       = axis_step(up, down, spd_q);
        sx           = $signed({2'b00, plat_x}) + step_x;
        sy           = $signed({2'b00, plat_y}) + step_y;
        sat_x        = sat_axis(sx, axis_bound(SW, plat_w));
        sat_y        = sat_axis(sy, axis_bound(SH, plat_h));
        moving       = (dir_q != 3'd0) && (spd_q != 5'd0);
        edge_hit     = moving && (sat_x[10] || sat_y[10]);
        contact_kill = (trig_q == 2'd2) && player_contact;
        timer_kill   = (trig_q == 2'd1) && tick && (life == 8'd0);
        edge_kill    = (trig_q == 2'd3) && tick && edge_hit;
        destroy      = live && (contact_kill || timer_kill || edge_kill);
        // Edge retirement keeps the saturated move; contact and timer retirement freeze it.
        move_en      = live && tick && moving && !contact_kill && !timer_kill;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // FSM next-state: replacement beats destroy; a retirement in ACK still finishes the handshake.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (!sync_platform_position) next_state = S_LOAD;
            S_LOAD:   next_state = S_ACK;
            S_ACK: begin
                if (destroy)
                    next_state = sync_platform_position ? S_IDLE : S_DRAIN;
                else if (sync_platform_position)
                    next_state = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!sync_platform_position)
                    next_state = S_LOAD;
                else if (destroy)
                    next_state = S_IDLE;
            end
            S_DRAIN:  if (sync_platform_position) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Descriptor latch, handshake, rectangle update and lifetime countdown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            update_platform_position <= 1'b0;
            platform_active          <= 1'b0;
            platform_destroyed       <= 1'b0;
            plat_x                   <= '0;
            plat_y                   <= '0;
            plat_w                   <= '0;
            plat_h                   <= '0;
            dir_q                    <= '0;
            spd_q                    <= '0;
            trig_q                   <= '0;
            life                     <= '0;
        end else begin
            platform_destroyed <= 1'b0;
            if (state == S_LOAD) begin
                plat_x                   <= pos_x;
                plat_y                   <= pos_y;
                plat_w                   <= w;
                plat_h                   <= h;
                dir_q                    <= movement_direction;
                spd_q                    <= speed;
                trig_q                   <= destroy_trigger;
                life                     <= destroy_time;
                update_platform_position <= 1'b1;
                platform_active          <= 1'b1;
            end else begin
                if (((state == S_ACK) || (state == S_DRAIN)) && sync_platform_position)
                    update_platform_position <= 1'b0;
                if (move_en) begin
                    plat_x <= sat_x[9:0];
                    plat_y <= sat_y[9:0];
                end
                if (destroy) begin
                    platform_destroyed <= 1'b1;
                    platform_active    <= 1'b0;
                end else if (live && tick && (life != 8'd0)) begin
                    life <= life - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_platform_motion_controller.sv
// Bench for platform_motion_controller: directed scenarios plus randomized
// descriptors checked against an arithmetic model of platform behaviour.
module tb_platform_motion_controller;

    localparam int TC = 4;
    localparam int SW = 640;
    localparam int SH = 480;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       sync  = 1'b1;
    logic [2:0] dir_i = '0;
    logic [4:0] spd_i = '0;
    logic [9:0] px = '0, py = '0, pw = '0, ph = '0;
    logic [7:0] dt_i  = '0;
    logic [1:0] trg_i = '0;
    logic       pc    = 1'b0;
    logic       ack, active, dstr;
    logic [9:0] ox, oy, ow, oh;

    int total  = 0;
    int passed = 0;

    // Bench-side view of the frame tick: the edge where the counter wraps.
    int   tb_cnt    = 0;
    logic last_tick = 1'b0;

    // Behavioural model of the live platform.
    int m_x, m_y, m_w, m_h, m_dir, m_spd, m_trig, m_life;
    bit m_live = 0;
    bit m_dst  = 0;
    int DXT [8] = '{0, 0, 0, -1, 1, -1, 1, 1};
    int DYT [8] = '{0, -1, 1, 0, 0, -1, -1, 1};

    platform_motion_controller #(
        .SCREEN_W   (SW),
        .SCREEN_H   (SH),
        .TICK_CYCLES(TC)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .sync_platform_position  (sync),
        .movement_direction      (dir_i),
        .speed                   (spd_i),
        .pos_x                   (px),
        .pos_y                   (py),
        .w                       (pw),
        .h                       (ph),
        .destroy_time            (dt_i),
        .destroy_trigger         (trg_i),
        .player_contact          (pc),
        .update_platform_position(ack),
        .platform_active         (active),
        .plat_x                  (ox),
        .plat_y                  (oy),
        .plat_w                  (ow),
        .plat_h                  (oh),
        .platform_destroyed      (dstr)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tb_cnt    <= 0;
            last_tick <= 1'b0;
        end else begin
            last_tick <= (tb_cnt == TC - 1);
            tb_cnt    <= (tb_cnt == TC - 1) ? 0 : tb_cnt + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance the model over the edge just taken.
    task automatic model_edge();
        int bx, by, nx, ny;
        bit hit;
        m_dst = 0;
        if (!m_live) return;
        if (m_trig == 2 && pc) begin
            m_live = 0; m_dst = 1; return;
        end
        if (!last_tick) return;
        if (m_trig == 1 && m_life == 0) begin
            m_live = 0; m_dst = 1; return;
        end
        if (m_life != 0) m_life--;
        if (m_dir == 0 || m_spd == 0) return;
        bx  = (m_w >= SW) ? 0 : SW - m_w;
        by  = (m_h >= SH) ? 0 : SH - m_h;
        nx  = m_x + DXT[m_dir] * m_spd;
        ny  = m_y + DYT[m_dir] * m_spd;
        hit = 0;
        if (nx < 0)  begin nx = 0;  hit = 1; end
        if (nx > bx) begin nx = bx; hit = 1; end
        if (ny < 0)  begin ny = 0;  hit = 1; end
        if (ny > by) begin ny = by; hit = 1; end
        m_x = nx;
        m_y = ny;
        if (m_trig == 3 && hit) begin
            m_live = 0; m_dst = 1;
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin cyc(); model_edge(); n++; end while (!last_tick && n < 2 * TC);
    endtask

    // Full 4-phase load, phase-aligned so the handshake edges never carry a tick.
    task automatic load_desc(input logic [2:0] d, input logic [4:0] s, input logic [9:0] x,
                             input logic [9:0] y, input logic [9:0] ww, input logic [9:0] hh,
                             input logic [7:0] t, input logic [1:0] tr, output bit saw);
        int n = 0;
        saw = 0;
        while (!last_tick && n < 2 * TC) begin cyc(); model_edge(); n++; end
        dir_i = d; spd_i = s; px = x; py = y; pw = ww; ph = hh; dt_i = t; trg_i = tr;
        sync = 1'b0;
        n = 0;
        do begin cyc(); n++; if (dstr) saw = 1; end while (ack !== 1'b1 && n < 8);
        total++;
        if (n !== 2) $display("FAIL ack_latency: got %0d cycles want 2", n);
        else passed++;
        total++;
        if ({active, ox, oy, ow, oh} !== {1'b1, x, y, ww, hh})
            $display("FAIL load_rect: got act=%b %0d,%0d %0dx%0d want 1 %0d,%0d %0dx%0d",
                     active, ox, oy, ow, oh, x, y, ww, hh);
        else passed++;
        m_x = x; m_y = y; m_w = ww; m_h = hh; m_dir = d; m_spd = s; m_trig = tr; m_life = t;
        m_live = 1; m_dst = 0;
        sync = 1'b1;
        cyc(); model_edge();
        if (dstr) saw = 1;
        total++;
        if (ack !== 1'b0) $display("FAIL ack_release: got %b want 0", ack);
        else passed++;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({ack, active, ox, oy, ow, oh, dstr} !== '0)
            $display("FAIL reset_outputs: got ack=%b act=%b x=%0d y=%0d w=%0d h=%0d d=%b want all 0",
                     ack, active, ox, oy, ow, oh, dstr);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        cyc(); cyc();
        total++;
        if ({ack, active, dstr} !== 3'b000) $display("FAIL idle_quiet: got %b want 000", {ack, active, dstr});
        else passed++;
    endtask

    task automatic test_load();
        bit saw;
        load_desc(3'd4, 5'd3, 10'd100, 10'd50, 10'd40, 10'd8, 8'd0, 2'd0, saw);
        for (int k = 1; k <= 3; k++) begin
            wait_tick();
            total++;
            if (ox !== 10'(100 + 3 * k) || oy !== 10'd50)
                $display("FAIL move_right tick%0d: got %0d,%0d want %0d,50", k, ox, oy, 100 + 3 * k);
            else passed++;
        end
    endtask

    task automatic test_edge();
        bit saw;
        load_desc(3'd4, 5'd31, 10'd590, 10'd100, 10'd40, 10'd8, 8'd0, 2'd0, saw);
        for (int k = 1; k <= 2; k++) begin
            wait_tick();
            total++;
            if (ox !== 10'd600 || active !== 1'b1 || dstr !== 1'b0)
                $display("FAIL edge_sat tick%0d: got x=%0d act=%b d=%b want 600 1 0", k, ox, active, dstr);
            else passed++;
        end
        load_desc(3'd4, 5'd31, 10'd590, 10'd100, 10'd40, 10'd8, 8'd0, 2'd3, saw);
        wait_tick();
        total++;
        if (dstr !== 1'b1 || active !== 1'b0 || ox !== 10'd600)
            $display("FAIL edge_destroy: got d=%b act=%b x=%0d want 1 0 600", dstr, active, ox);
        else passed++;
        cyc(); model_edge();
        total++;
        if (dstr !== 1'b0) $display("FAIL edge_pulse_width: got %b want 0", dstr);
        else passed++;
    endtask

    task automatic test_timer();
        bit saw;
        load_desc(3'd0, 5'd9, 10'd200, 10'd200, 10'd20, 10'd20, 8'd2, 2'd1, saw);
        for (int k = 1; k <= 3; k++) begin
            wait_tick();
            total++;
            if (dstr !== (k == 3) || active !== (k != 3))
                $display("FAIL timer2 tick%0d: got d=%b act=%b want %b %b", k, dstr, active, k == 3, k != 3);
            else passed++;
        end
        load_desc(3'd0, 5'd0, 10'd30, 10'd40, 10'd20, 10'd20, 8'd0, 2'd1, saw);
        wait_tick();
        total++;
        if (dstr !== 1'b1 || active !== 1'b0 || ox !== 10'd30)
            $display("FAIL timer0: got d=%b act=%b x=%0d want 1 0 30", dstr, active, ox);
        else passed++;
    endtask

    task automatic test_contact();
        bit saw;
        int xb, n;
        for (int tr = 2; tr >= 0; tr -= 2) begin
            load_desc(3'd4, 5'd5, 10'd100, 10'd60, 10'd30, 10'd10, 8'd0, 2'(tr), saw);
            n = 0;
            while (tb_cnt != TC - 1 && n < 2 * TC) begin cyc(); model_edge(); n++; end
            xb = m_x;
            pc = 1'b1;
            cyc(); model_edge();
            pc = 1'b0;
            total++;
            if (tr == 2 && (dstr !== 1'b1 || active !== 1'b0 || ox !== 10'(xb)))
                $display("FAIL contact_destroy: got d=%b act=%b x=%0d want 1 0 %0d", dstr, active, ox, xb);
            else if (tr == 0 && (dstr !== 1'b0 || active !== 1'b1 || ox !== 10'(xb + 5)))
                $display("FAIL contact_ignored: got d=%b act=%b x=%0d want 0 1 %0d", dstr, active, ox, xb + 5);
            else passed++;
            cyc(); model_edge();
            total++;
            if (dstr !== 1'b0) $display("FAIL contact_pulse_width: got %b want 0", dstr);
            else passed++;
        end
    endtask

    task automatic test_replace();
        bit saw;
        load_desc(3'd2, 5'd1, 10'd300, 10'd300, 10'd16, 10'd16, 8'd0, 2'd0, saw);
        for (int k = 0; k < 5; k++) begin cyc(); model_edge(); end
        load_desc(3'd0, 5'd0, 10'd10, 10'd10, 10'd50, 10'd5, 8'd0, 2'd0, saw);
        total++;
        if (saw !== 1'b0) $display("FAIL replace_no_pulse: got %b want 0", saw);
        else passed++;
        for (int k = 0; k < 6; k++) begin cyc(); model_edge(); end
        total++;
        if ({active, ox, oy} !== {1'b1, 10'd10, 10'd10})
            $display("FAIL replace_hold: got act=%b %0d,%0d want 1 10,10", active, ox, oy);
        else passed++;
    endtask

    task automatic test_random();
        bit saw;
        logic [9:0] ww, hh, x, y;
        int bx, by;
        for (int it = 0; it < 24; it++) begin
            ww = 10'($urandom_range(700, 1));
            hh = 10'($urandom_range(520, 1));
            bx = (int'(ww) >= SW) ? 0 : SW - int'(ww);
            by = (int'(hh) >= SH) ? 0 : SH - int'(hh);
            x  = 10'($urandom_range(bx, 0));
            y  = 10'($urandom_range(by, 0));
            load_desc(3'($urandom_range(7, 0)), 5'($urandom_range(31, 0)), x, y, ww, hh,
                      8'd0, ($urandom_range(1, 0) == 1) ? 2'd3 : 2'd0, saw);
            for (int k = 0; k < 14; k++) begin
                cyc(); model_edge();
                total++;
                if ({ox, oy, ow, oh} !== {10'(m_x), 10'(m_y), 10'(m_w), 10'(m_h)})
                    $display("FAIL rand_rect it%0d c%0d: got %0d,%0d want %0d,%0d", it, k, ox, oy, m_x, m_y);
                else passed++;
                total++;
                if (active !== m_live || dstr !== m_dst)
                    $display("FAIL rand_status it%0d c%0d: got act=%b d=%b want %b %b",
                             it, k, active, dstr, m_live, m_dst);
                else passed++;
            end
        end
    endtask

    task automatic test_async_reset();
        bit saw;
        int n = 0;
        dir_i = 3'd4; spd_i = 5'd2; px = 10'd77; py = 10'd88; pw = 10'd10; ph = 10'd10;
        dt_i = 8'd0; trg_i = 2'd0;
        sync = 1'b0;
        do begin cyc(); n++; end while (ack !== 1'b1 && n < 8);
        total++;
        if (ack !== 1'b1) $display("FAIL rst_pre_ack: got %b want 1", ack);
        else passed++;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({ack, active, ox, oy, ow, oh, dstr} !== '0)
            $display("FAIL async_reset: got ack=%b act=%b x=%0d y=%0d d=%b want all 0", ack, active, ox, oy, dstr);
        else passed++;
        m_live = 0;
        @(negedge clk);
        sync  = 1'b1;
        reset = 1'b1;
        cyc(); cyc();
        total++;
        if ({ack, active} !== 2'b00) $display("FAIL post_reset_idle: got %b want 00", {ack, active});
        else passed++;
        load_desc(3'd1, 5'd4, 10'd200, 10'd200, 10'd20, 10'd20, 8'd0, 2'd0, saw);
        wait_tick();
        total++;
        if ({ox, oy} !== {10'd200, 10'd196}) $display("FAIL post_reset_move: got %0d,%0d want 200,196", ox, oy);
        else passed++;
    endtask

    initial begin
        #1 reset = 1'b0;
        test_reset();
        test_load();
        test_edge();
        test_timer();
        test_contact();
        test_replace();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
